// File: rtl/seq_shifter.sv
// seq_shifter: bit-serial shift unit for the multicycle-op path.
// One bit of SLL/SRA/SRL/ROR per cycle; latency is shamt+1 cycles.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_shift,
    input  logic             ctrl_abort,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [SHW-1:0]   cnt_q;
    logic [1:0]       opr_q;
    logic [WIDTH-1:0] result_q;
    logic             rdy_q;

    // One-bit step of the accumulator for the latched op.
    always_comb begin
        acc_d = acc_q;
        unique case (opr_q)
            OP_SLL: acc_d = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRA: acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            OP_SRL: acc_d = {1'b0, acc_q[WIDTH-1:1]};
            OP_ROR: acc_d = {acc_q[0], acc_q[WIDTH-1:1]};
            default: acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            opr_q    <= '0;
            result_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ctrl_shift) begin
                        acc_q   <= data_operandA;
                        cnt_q   <= shamt;
                        opr_q   <= op;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Abort wins over completion in the same cycle.
                    if (ctrl_abort) begin
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - SHW'(1);
                    end else begin
                        result_q <= acc_q;
                        rdy_q    <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q == SHIFT);

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed plus random ops against an arithmetic
// shift model; checks result, latency, busy, abort and reset.
module tb_seq_shifter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_shift = 1'b0;
    logic        ctrl_abort = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [4:0]  shamt = '0;
    logic [1:0]  op = '0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    seq_shifter #(.WIDTH(32), .SHW(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_shift     (ctrl_shift),
        .ctrl_abort     (ctrl_abort),
        .data_operandA  (data_operandA),
        .shamt          (shamt),
        .op             (op),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: run time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a,
                                          input int s,
                                          input logic [1:0] o);
        case (o)
            2'd0: return a << s;
            2'd1: return 32'($signed(a) >>> s);
            2'd2: return a >> s;
            default: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
        endcase
    endfunction

    task automatic scramble();
        data_operandA = $urandom;
        shamt = 5'($urandom);
        op = 2'($urandom);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start(input logic [31:0] a, input logic [4:0] s,
                         input logic [1:0] o, input logic ab);
        ctrl_shift = 1'b1;
        ctrl_abort = ab;
        data_operandA = a;
        shamt = s;
        op = o;
        @(posedge clock);
        @(negedge clock);
        ctrl_shift = 1'b0;
        ctrl_abort = 1'b0;
        scramble();
    endtask

    // poke: cycle index at which a stray start is driven mid-op (-1 none).
    task automatic wait_done(input string tag, input logic [31:0] exp,
                             input int s, input int poke);
        int c = 0;
        while (!data_resultRDY && c <= s + 4) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            if (c == poke) begin
                ctrl_shift = 1'b1;
                scramble();
            end else begin
                ctrl_shift = 1'b0;
            end
            @(negedge clock);
            c++;
        end
        ctrl_shift = 1'b0;
        check({tag, "_lat"}, 32'(c), 32'(s + 1));
        check({tag, "_res"}, data_result, exp);
        check({tag, "_busyfall"}, 32'(busy), 32'd0);
        if (data_resultRDY) last_res = exp;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a,
                          input int s, input logic [1:0] o);
        start(a, 5'(s), o, 1'b0);
        wait_done(tag, model(a, s, o), s, -1);
    endtask

    task automatic abort_op(input string tag, input logic [31:0] a,
                            input int s, input int at);
        start(a, 5'(s), 2'($urandom), 1'b0);
        for (int c = 0; c < at; c++) begin
            check({tag, "_noRdy"}, 32'(data_resultRDY), 32'd0);
            @(negedge clock);
        end
        ctrl_abort = 1'b1;
        @(negedge clock);
        ctrl_abort = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rdy"}, 32'(data_resultRDY), 32'd0);
        check({tag, "_res"}, data_result, last_res);
        for (int k = 0; k < s + 2; k++) begin
            @(negedge clock);
            check({tag, "_late"}, 32'(data_resultRDY), 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_res", data_result, 32'd0);
        check("rst_rdy", 32'(data_resultRDY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("rel_busy", 32'(busy), 32'd0);

        ctrl_abort = 1'b1;
        @(negedge clock);
        ctrl_abort = 1'b0;
        check("idle_abort", 32'(busy), 32'd0);

        run_op("sra4", 32'h8000_0000, 4, 2'd1);
        check("sra4_exp", last_res, 32'hF800_0000);
        run_op("sll31", 32'h0000_0001, 31, 2'd0);
        run_op("srl31", 32'h8000_0000, 31, 2'd2);
        run_op("ror0", 32'h1234_5678, 0, 2'd3);
        run_op("ror1", 32'h0000_0001, 1, 2'd3);
        check("ror1_exp", last_res, 32'h8000_0000);

        start(32'hFFFF_0000, 5'd8, 2'd1, 1'b0);
        wait_done("ignore", 32'hFFFF_FF00, 8, 3);
        run_op("b2b", 32'hA5A5_0F0F, 7, 2'd3);

        start(32'h0F0F_0001, 5'd3, 2'd0, 1'b1);
        wait_done("startabort", 32'h7878_0008, 3, -1);

        abort_op("abort2", 32'hDEAD_BEEF, 10, 2);
        abort_op("abortend", 32'h1357_9BDF, 6, 6);
        run_op("postabort", 32'h0000_00FF, 5, 2'd0);
        @(negedge clock);
        check("rdy_pulse", 32'(data_resultRDY), 32'd0);

        start(32'hCAFE_F00D, 5'd20, 2'd2, 1'b0);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("arst_res", data_result, 32'd0);
        check("arst_rdy", 32'(data_resultRDY), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        last_res = '0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            check("arst_noRdy", 32'(data_resultRDY), 32'd0);
        end
        run_op("fresh", 32'h8000_0001, 9, 2'd3);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int          s;
            logic [1:0]  o;
            a = $urandom;
            s = int'($urandom_range(31, 0));
            o = 2'($urandom);
            start(a, 5'(s), o, 1'($urandom));
            wait_done("rand", model(a, s, o), s, -1);
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clock);
                check("rand_pulse", 32'(data_resultRDY), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
